// File: rtl/cci_memcpy_copy_engine.sv
// Line-granular CCI-P copy engine: reads src lines over c0 (tagged by slot), writes them to dst over c1.
// Minimal CCI-P type package lives alongside the engine so the block builds stand-alone.
package ccip_if_pkg;
  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [15:0]  t_ccip_mdata;
  typedef logic [511:0] t_ccip_clData;
  typedef logic [1:0]   t_ccip_clNum;

  typedef enum logic [1:0] {eVC_VA = 2'h0, eVC_VL0 = 2'h1, eVC_VH0 = 2'h2, eVC_VH1 = 2'h3} t_ccip_vc;
  typedef enum logic [1:0] {eCL_LEN_1 = 2'b00, eCL_LEN_2 = 2'b01, eCL_LEN_4 = 2'b11} t_ccip_clLen;
  typedef enum logic [3:0] {eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1} t_ccip_c0_req;
  typedef enum logic [3:0] {eREQ_WRLINE_I = 4'h0, eREQ_WRLINE_M = 4'h1, eREQ_WRPUSH_I = 4'h2,
                            eREQ_WRFENCE = 4'h4, eREQ_INTR = 4'h6} t_ccip_c1_req;
  typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;
  typedef enum logic [3:0] {eRSP_WRLINE = 4'h0, eRSP_WRFENCE = 4'h4, eRSP_INTR = 4'h6} t_ccip_c1_rsp;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic [1:0]   rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic [5:0]   rsvd2;
    t_ccip_vc     vc_sel;
    logic         sop;
    logic         rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    t_ccip_clNum  cl_num;
    t_ccip_c0_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic         format;
    logic         rsvd0;
    t_ccip_clNum  cl_num;
    t_ccip_c1_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;
endpackage

// Handshake: a request is issued when its channel's almost-full flag is low in the issuing cycle;
// sTx valids are registered pulses (one cycle per request), responses are accepted whenever rspValid is high.
module cci_memcpy_copy_engine
  import ccip_if_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 32,
  parameter int TAG_W           = $clog2(MAX_OUTSTANDING)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [63:0]  size_lines,
  input  t_ccip_clAddr src_addr,
  input  t_ccip_clAddr dst_addr,
  input  t_if_ccip_Rx  sRx,
  output t_if_ccip_Tx  sTx,
  output logic         busy,
  output logic         finished,
  output logic [63:0]  lines_written,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} t_state;

  t_state       state;
  logic [63:0]  size_q;
  logic [63:0]  rd_idx;
  logic [63:0]  wr_acked;
  t_ccip_clAddr src_q;
  t_ccip_clAddr dst_q;

  logic [63:0]                slot_off [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] slot_busy;
  logic [MAX_OUTSTANDING-1:0] slot_busy_nxt;

  // Response FIFO: one extra pointer bit distinguishes full from empty.
  logic [TAG_W-1:0] fifo_tag  [MAX_OUTSTANDING];
  t_ccip_clData     fifo_data [MAX_OUTSTANDING];
  logic [TAG_W:0]   wr_ptr;
  logic [TAG_W:0]   rd_ptr;

  logic             alloc_ok;
  logic [TAG_W-1:0] alloc_slot;
  logic             fifo_empty;
  logic             start_ok;
  logic             rd_fire;
  logic             rsp_push;
  logic             wr_fire;
  logic [TAG_W-1:0] rsp_tag;
  logic [TAG_W-1:0] pop_tag;
  t_ccip_clData     pop_data;
  logic [63:0]      rd_addr64;
  logic [63:0]      wr_addr64;
  logic             ack_valid;
  logic [63:0]      ack_inc;
  logic [63:0]      wr_acked_nxt;
  logic             unused_ok;

  // Lowest-index free slot; searched from the top so the last hit wins.
  always_comb begin
    alloc_ok   = 1'b0;
    alloc_slot = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!slot_busy[i]) begin
        alloc_ok   = 1'b1;
        alloc_slot = TAG_W'(i);
      end
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign rd_fire    = (state == ST_RUN) && (rd_idx < size_q) && alloc_ok && !sRx.c0TxAlmFull;
  assign rsp_push   = (state == ST_RUN) && sRx.c0.rspValid && (sRx.c0.hdr.resp_type == eRSP_RDLINE);
  assign wr_fire    = !fifo_empty && !sRx.c1TxAlmFull;
  assign rsp_tag    = sRx.c0.hdr.mdata[TAG_W-1:0];
  assign pop_tag    = fifo_tag[rd_ptr[TAG_W-1:0]];
  assign pop_data   = fifo_data[rd_ptr[TAG_W-1:0]];
  assign rd_addr64  = {22'b0, src_q} + rd_idx;
  assign wr_addr64  = {22'b0, dst_q} + slot_off[pop_tag];

  assign ack_valid    = (state == ST_RUN) && sRx.c1.rspValid && (sRx.c1.hdr.resp_type == eRSP_WRLINE);
  assign ack_inc      = sRx.c1.hdr.format ? (64'(sRx.c1.hdr.cl_num) + 64'd1) : 64'd1;
  assign wr_acked_nxt = wr_acked + (ack_valid ? ack_inc : 64'd0);

  // The freed and allocated slots can never coincide: allocation only looks at free slots.
  always_comb begin
    slot_busy_nxt = slot_busy;
    if (wr_fire) slot_busy_nxt[pop_tag] = 1'b0;
    if (rd_fire) slot_busy_nxt[alloc_slot] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      finished      <= 1'b0;
      lines_written <= '0;
      wr_acked      <= '0;
      rd_idx        <= '0;
      size_q        <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      slot_busy     <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      sTx           <= '0;
    end else begin
      sTx.c2       <= '0;
      sTx.c0.valid <= rd_fire;
      if (rd_fire) begin
        sTx.c0.hdr.vc_sel   <= eVC_VA;
        sTx.c0.hdr.rsvd1    <= '0;
        sTx.c0.hdr.cl_len   <= eCL_LEN_1;
        sTx.c0.hdr.req_type <= eREQ_RDLINE_I;
        sTx.c0.hdr.rsvd0    <= '0;
        sTx.c0.hdr.address  <= rd_addr64[41:0];
        sTx.c0.hdr.mdata    <= {{(16-TAG_W){1'b0}}, alloc_slot};
        rd_idx              <= rd_idx + 64'd1;
      end

      sTx.c1.valid <= wr_fire;
      if (wr_fire) begin
        sTx.c1.hdr.rsvd2    <= '0;
        sTx.c1.hdr.vc_sel   <= eVC_VA;
        sTx.c1.hdr.sop      <= 1'b1;
        sTx.c1.hdr.rsvd1    <= 1'b0;
        sTx.c1.hdr.cl_len   <= eCL_LEN_1;
        sTx.c1.hdr.req_type <= eREQ_WRLINE_I;
        sTx.c1.hdr.rsvd0    <= '0;
        sTx.c1.hdr.address  <= wr_addr64[41:0];
        sTx.c1.hdr.mdata    <= '0;
        sTx.c1.data         <= pop_data;
        rd_ptr              <= rd_ptr + 1'b1;
      end

      slot_busy <= slot_busy_nxt;
      if (rsp_push) wr_ptr <= wr_ptr + 1'b1;

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            size_q        <= size_lines;
            src_q         <= src_addr;
            dst_q         <= dst_addr;
            rd_idx        <= '0;
            wr_acked      <= '0;
            lines_written <= '0;
            if (size_lines == 64'd0) begin
              state    <= ST_DONE;
              busy     <= 1'b0;
              finished <= 1'b1;
            end else begin
              state    <= ST_RUN;
              busy     <= 1'b1;
              finished <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (ack_valid) begin
            wr_acked      <= wr_acked_nxt;
            lines_written <= lines_written + ack_inc;
          end
          // Finish on the edge that absorbs the last acknowledgement.
          if (wr_acked_nxt == size_q) begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            finished <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          finished <= 1'b0;
        end
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by slot_busy and the FIFO pointers.
  always_ff @(posedge clk) begin
    if (rd_fire) slot_off[alloc_slot] <= rd_idx;
    if (rsp_push) begin
      fifo_tag[wr_ptr[TAG_W-1:0]]  <= rsp_tag;
      fifo_data[wr_ptr[TAG_W-1:0]] <= sRx.c0.data;
    end
  end

  assign state_dbg = state;
  assign unused_ok = ^{sRx, rd_addr64[63:42], wr_addr64[63:42]};

endmodule

// File: tb/tb_cci_memcpy_copy_engine.sv
// Bench for the copy engine: host-memory model answers reads/writes; a scoreboard checks every request.
module tb_cci_memcpy_copy_engine;
  import ccip_if_pkg::*;

  localparam int MAXO = 32;
  localparam int EW   = 42 + 512;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [63:0]  size_lines = '0;
  t_ccip_clAddr src_addr = '0;
  t_ccip_clAddr dst_addr = '0;
  t_if_ccip_Rx  sRx;
  t_if_ccip_Tx  sTx;
  logic         busy;
  logic         finished;
  logic [63:0]  lines_written;
  logic [1:0]   state_dbg;

  cci_memcpy_copy_engine #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .start(start), .size_lines(size_lines),
    .src_addr(src_addr), .dst_addr(dst_addr), .sRx(sRx), .sTx(sTx),
    .busy(busy), .finished(finished), .lines_written(lines_written), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Response drive variables combined into sRx.
  logic         c0_alm = 1'b0;
  logic         c1_alm = 1'b0;
  logic         r0_valid = 1'b0;
  logic [15:0]  r0_tag = '0;
  logic [511:0] r0_data = '0;
  logic         r1_valid = 1'b0;
  logic         r1_format = 1'b0;
  logic [1:0]   r1_clnum = '0;

  always_comb begin
    sRx                    = '0;
    sRx.c0TxAlmFull        = c0_alm;
    sRx.c1TxAlmFull        = c1_alm;
    sRx.c0.rspValid        = r0_valid;
    sRx.c0.hdr.resp_type   = eRSP_RDLINE;
    sRx.c0.hdr.mdata       = r0_tag;
    sRx.c0.data            = r0_data;
    sRx.c1.rspValid        = r1_valid;
    sRx.c1.hdr.resp_type   = eRSP_WRLINE;
    sRx.c1.hdr.format      = r1_format;
    sRx.c1.hdr.cl_num      = r1_clnum;
  end

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [41:0]   rd_exp_q[$];
  int            pend_tag[$];
  logic [41:0]   pend_addr[$];
  int            pend_due[$];
  int            wack_due[$];

  int           n_checks = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           n_reads = 0;
  int           n_writes = 0;
  int           copy_rd_base = 0;
  int           lat_lo = 5;
  int           lat_hi = 5;
  bit           stale = 1'b0;
  bit           packed_ack = 1'b0;
  bit           toggle_c1 = 1'b0;
  logic [41:0]  cur_src = '0;
  logic [41:0]  cur_dst = '0;
  logic         prev_c0_alm = 1'b0;
  logic         prev_c1_alm = 1'b0;
  logic         prev_fin = 1'b0;
  int           fin_cyc = 0;
  int           last_ack_cyc = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] data_of(input logic [41:0] a);
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = (a[31:0] * 32'h9E37_79B1) ^ (32'h0101_0101 * 32'(k));
    return d;
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Host memory model: answers due reads (possibly out of order) and acknowledges writes.
  always @(posedge clk) begin
    int idx;
    logic [511:0] d;
    cyc++;
    #1;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    r1_format = 1'b0;
    r1_clnum = '0;
    idx = -1;
    for (int i = 0; i < pend_due.size(); i++) begin
      if (idx < 0 && pend_due[i] <= cyc) idx = i;
    end
    if (idx >= 0) begin
      d = data_of(pend_addr[idx]);
      r0_valid = 1'b1;
      r0_tag = 16'(pend_tag[idx]);
      r0_data = d;
      if (!stale) exp_q.push_back({cur_dst + (pend_addr[idx] - cur_src), d});
      pend_tag.delete(idx);
      pend_addr.delete(idx);
      pend_due.delete(idx);
    end
    if (packed_ack) begin
      if (wack_due.size() >= 4 && wack_due[3] <= cyc) begin
        repeat (4) void'(wack_due.pop_front());
        r1_valid = 1'b1;
        r1_format = 1'b1;
        r1_clnum = 2'd3;
        last_ack_cyc = cyc;
      end
    end else if (wack_due.size() > 0 && wack_due[0] <= cyc) begin
      void'(wack_due.pop_front());
      r1_valid = 1'b1;
      last_ack_cyc = cyc;
    end
    if (toggle_c1) begin
      if (cyc % 3 == 0) c1_alm = ~c1_alm;
    end else begin
      c1_alm = 1'b0;
    end
  end

  // Monitor: checks every presented request against the expected queues.
  always @(negedge clk) begin
    logic [41:0]  ea;
    logic [EW-1:0] e;
    bit dup;
    if (!reset) begin
      if (sTx.c0.valid) begin
        chk("c0_after_almfull", prev_c0_alm, 1'b0);
        chk("rd_req_type", sTx.c0.hdr.req_type, eREQ_RDLINE_I);
        chk("rd_cl_len", sTx.c0.hdr.cl_len, eCL_LEN_1);
        if (stale) begin
          ea = sTx.c0.hdr.address;
        end else begin
          if (rd_exp_q.size() == 0) begin
            chk("rd_unexpected", 1'b1, 1'b0);
            ea = sTx.c0.hdr.address;
          end else begin
            ea = rd_exp_q.pop_front();
            chk("rd_addr", sTx.c0.hdr.address, ea);
          end
          if (n_reads == copy_rd_base) chk("rd_first_tag", sTx.c0.hdr.mdata, 16'd0);
          dup = 1'b0;
          foreach (pend_tag[i]) if (pend_tag[i] == int'(sTx.c0.hdr.mdata)) dup = 1'b1;
          chk("rd_tag_unique", dup, 1'b0);
          chk("rd_outstanding_le_max", pend_tag.size() < MAXO, 1'b1);
        end
        n_reads++;
        pend_tag.push_back(int'(sTx.c0.hdr.mdata));
        pend_addr.push_back(ea);
        pend_due.push_back(cyc + $urandom_range(lat_hi, lat_lo));
      end
      if (sTx.c1.valid) begin
        n_writes++;
        chk("c1_after_almfull", prev_c1_alm, 1'b0);
        chk("wr_sop", sTx.c1.hdr.sop, 1'b1);
        chk("wr_mdata", sTx.c1.hdr.mdata, 16'd0);
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", sTx.c1.hdr.address, e[EW-1:512]);
          chk("wr_data", sTx.c1.data, e[511:0]);
        end
        wack_due.push_back(cyc + $urandom_range(8, 3));
      end
      if (finished && !prev_fin) fin_cyc = cyc;
    end
    prev_fin    = finished;
    prev_c0_alm = c0_alm;
    prev_c1_alm = c1_alm;
  end

  task automatic wait_finished(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      if (finished) break;
    end
    chk("finished_within_budget", finished, 1'b1);
  endtask

  task automatic run_copy(input int n, input logic [41:0] s, input logic [41:0] d,
                          input bit pk, input int lo, input int hi, input bit almtest);
    int r0, w0;
    cur_src = s;
    cur_dst = d;
    packed_ack = pk;
    lat_lo = lo;
    lat_hi = hi;
    r0 = n_reads;
    w0 = n_writes;
    copy_rd_base = n_reads;
    for (int i = 0; i < n; i++) rd_exp_q.push_back(s + 42'(i));
    size_lines = 64'(n);
    src_addr = s;
    dst_addr = d;
    if (almtest) c0_alm = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    if (almtest) begin
      repeat (20) tick;
      chk("no_reads_under_c0_almfull", n_reads - r0, 0);
      c0_alm = 1'b0;
      toggle_c1 = 1'b1;
    end
    wait_finished(20000);
    toggle_c1 = 1'b0;
    repeat (15) tick;
    chk("lines_written", lines_written, 64'(n));
    chk("read_count", n_reads - r0, n);
    chk("write_count", n_writes - w0, n);
    chk("reads_all_seen", rd_exp_q.size(), 0);
    chk("writes_all_seen", exp_q.size(), 0);
    chk("busy_low_when_done", busy, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time budget exhausted");
    $fatal(1);
  end

  initial begin
    int base, w0;
    reset = 1'b1;
    repeat (3) tick;
    reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_finished", finished, 1'b0);
    chk("rst_lines_written", lines_written, 64'd0);
    chk("rst_c0_valid", sTx.c0.valid, 1'b0);
    chk("rst_c1_valid", sTx.c1.valid, 1'b0);
    chk("rst_c2_valid", sTx.c2.mmioRdValid, 1'b0);
    chk("rst_state", state_dbg, 2'd0);

    // Zero-length copy: DONE on the edge after start, no traffic.
    size_lines = 64'd0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("zero_finished", finished, 1'b1);
    chk("zero_busy", busy, 1'b0);
    repeat (20) tick;
    chk("zero_no_reads", n_reads, 0);
    chk("zero_no_writes", n_writes, 0);

    run_copy(1, 42'h1000, 42'h2000, 1'b0, 10, 10, 1'b0);
    run_copy(100, 42'h4_0000, 42'h8_0000, 1'b0, 5, 60, 1'b0);
    run_copy(64, 42'h1_0000, 42'h2_0000, 1'b0, 5, 20, 1'b1);

    run_copy(16, 42'h3000, 42'h5000, 1'b1, 5, 30, 1'b0);
    chk("packed_done_on_last_ack", fin_cyc, last_ack_cyc + 1);
    packed_ack = 1'b0;

    // Reset while reads are in flight; their late responses must be dropped.
    base = n_reads;
    copy_rd_base = n_reads;
    cur_src = 42'h8000;
    cur_dst = 42'h9000;
    lat_lo = 80;
    lat_hi = 90;
    for (int i = 0; i < 40; i++) rd_exp_q.push_back(42'h8000 + 42'(i));
    size_lines = 64'd40;
    src_addr = 42'h8000;
    dst_addr = 42'h9000;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (n_reads - base >= 10) break;
    end
    chk("reset_test_outstanding", pend_tag.size(), 10);
    stale = 1'b1;
    rd_exp_q.delete();
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    w0 = n_writes;
    for (int i = 0; i < 300; i++) begin
      if (pend_tag.size() == 0) break;
      tick;
    end
    chk("stale_responses_delivered", pend_tag.size(), 0);
    repeat (10) tick;
    chk("stale_no_writes", n_writes - w0, 0);
    chk("stale_finished_low", finished, 1'b0);
    chk("stale_busy_low", busy, 1'b0);
    chk("stale_lines_written", lines_written, 64'd0);
    stale = 1'b0;
    run_copy(4, 42'h100, 42'h300, 1'b0, 5, 15, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
